// File: rtl/vend_purchase_ctrl_if.sv
// Customer/owner-facing signal bundle of the vending purchase controller.
// The slave modport is the controller; master is the machine front panel side.
interface vend_purchase_ctrl_if;
  logic       mode;
  logic       coin_valid;
  logic [1:0] coin;
  logic       sel_valid;
  logic [1:0] sel;
  logic       cancel;
  logic       change_ack;
  logic       acc_clr;
  logic [4:0] machineAcc;
  logic [4:0] credit;
  logic       dispense_valid;
  logic [1:0] dispense_item;
  logic       change_valid;
  logic [4:0] change_amt;
  logic       coin_reject;
  logic       err_funds;
  logic       err_full;
  logic       greenLight;

  modport master (
    output mode, coin_valid, coin, sel_valid, sel, cancel, change_ack, acc_clr,
    input  machineAcc, credit, dispense_valid, dispense_item, change_valid,
           change_amt, coin_reject, err_funds, err_full, greenLight
  );

  modport slave (
    input  mode, coin_valid, coin, sel_valid, sel, cancel, change_ack, acc_clr,
    output machineAcc, credit, dispense_valid, dispense_item, change_valid,
           change_amt, coin_reject, err_funds, err_full, greenLight
  );
endinterface

// File: rtl/vend_purchase_ctrl.sv
// Purchase controller: collects coins, vends priced items, returns change and
// keeps the 5-bit sales account read by the owner-retrieve stage.
module vend_purchase_ctrl #(
  parameter int unsigned PRICE0 = 3,
  parameter int unsigned PRICE1 = 5,
  parameter int unsigned PRICE2 = 7,
  parameter int unsigned PRICE3 = 10
) (
  input logic clk,
  input logic rst_n,
  vend_purchase_ctrl_if.slave bus
);

  typedef enum logic [1:0] {IDLE, COLLECT, VEND, CHANGE} state_t;

  state_t     stateReg, stateNext;
  logic [4:0] creditReg, creditNext;
  logic [4:0] accReg, accNext;
  logic [4:0] changeAmtReg, changeAmtNext;
  logic [1:0] selReg, selNext;
  logic       dispValidReg, dispValidNext;
  logic       changeValidReg, changeValidNext;
  logic       coinRejReg, coinRejNext;
  logic       errFundsReg, errFundsNext;
  logic       errFullReg, errFullNext;

  localparam int unsigned PRICES [4] = '{PRICE0, PRICE1, PRICE2, PRICE3};
  logic [4:0] priceTab [4];

  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_price
      assign priceTab[gi] = 5'(PRICES[gi]);
    end
  endgenerate

  logic [4:0] coinVal;
  always_comb begin
    coinVal = 5'd1;
    case (bus.coin)
      2'b00: coinVal = 5'd1;
      2'b01: coinVal = 5'd2;
      2'b10: coinVal = 5'd5;
      2'b11: coinVal = 5'd10;
      default: coinVal = 5'd1;
    endcase
  end

  // Sums are formed one bit wider so overflow is detected, never truncated.
  logic [5:0] coinSum, accSum;
  logic [4:0] selPrice, vendPrice, remain;
  logic       fundsOk, fullOk;

  assign selPrice  = priceTab[bus.sel];
  assign vendPrice = priceTab[selReg];
  assign coinSum   = {1'b0, creditReg} + {1'b0, coinVal};
  assign accSum    = {1'b0, accReg} + {1'b0, selPrice};
  assign fundsOk   = creditReg >= selPrice;
  assign fullOk    = accSum <= 6'd31;
  assign remain    = creditReg - vendPrice;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stateReg       <= IDLE;
      creditReg      <= '0;
      accReg         <= '0;
      changeAmtReg   <= '0;
      selReg         <= '0;
      dispValidReg   <= 1'b0;
      changeValidReg <= 1'b0;
      coinRejReg     <= 1'b0;
      errFundsReg    <= 1'b0;
      errFullReg     <= 1'b0;
    end else begin
      stateReg       <= stateNext;
      creditReg      <= creditNext;
      accReg         <= accNext;
      changeAmtReg   <= changeAmtNext;
      selReg         <= selNext;
      dispValidReg   <= dispValidNext;
      changeValidReg <= changeValidNext;
      coinRejReg     <= coinRejNext;
      errFundsReg    <= errFundsNext;
      errFullReg     <= errFullNext;
    end
  end

  // Owner mode in COLLECT takes precedence over every customer strobe.
  always_comb begin
    stateNext = stateReg;
    case (stateReg)
      IDLE:
        if (bus.coin_valid && !bus.mode) stateNext = COLLECT;
      COLLECT:
        if (bus.mode)                                  stateNext = (creditReg != 5'd0) ? CHANGE : IDLE;
        else if (bus.cancel)                           stateNext = CHANGE;
        else if (bus.sel_valid && fundsOk && fullOk)   stateNext = VEND;
      VEND:
        stateNext = (remain != 5'd0) ? CHANGE : IDLE;
      CHANGE:
        if (bus.change_ack) stateNext = IDLE;
      default:
        stateNext = IDLE;
    endcase
  end

  always_comb begin
    creditNext      = creditReg;
    accNext         = accReg;
    selNext         = selReg;
    changeAmtNext   = changeAmtReg;
    changeValidNext = changeValidReg;
    dispValidNext   = 1'b0;
    coinRejNext     = 1'b0;
    errFundsNext    = 1'b0;
    errFullNext     = 1'b0;
    if (bus.mode && bus.acc_clr && stateReg != VEND) accNext = '0;

    case (stateReg)
      IDLE: begin
        creditNext = '0;
        if (bus.coin_valid) begin
          if (bus.mode) coinRejNext = 1'b1;
          else          creditNext  = coinVal;
        end
      end
      COLLECT: begin
        if (bus.mode) begin
          coinRejNext = bus.coin_valid;
          if (creditReg != 5'd0) begin
            changeValidNext = 1'b1;
            changeAmtNext   = creditReg;
          end
        end else if (bus.cancel) begin
          coinRejNext     = bus.coin_valid;
          changeValidNext = 1'b1;
          changeAmtNext   = creditReg;
        end else if (bus.sel_valid) begin
          coinRejNext = bus.coin_valid;
          if (!fundsOk)     errFundsNext = 1'b1;
          else if (!fullOk) errFullNext  = 1'b1;
          else begin
            selNext       = bus.sel;
            dispValidNext = 1'b1;
          end
        end else if (bus.coin_valid) begin
          if (coinSum <= 6'd31) creditNext  = coinSum[4:0];
          else                  coinRejNext = 1'b1;
        end
      end
      VEND: begin
        coinRejNext = bus.coin_valid;
        accNext     = accReg + vendPrice;
        creditNext  = remain;
        if (remain != 5'd0) begin
          changeValidNext = 1'b1;
          changeAmtNext   = remain;
        end
      end
      CHANGE: begin
        coinRejNext = bus.coin_valid;
        if (bus.change_ack) begin
          creditNext      = '0;
          changeValidNext = 1'b0;
        end
      end
      default: ;
    endcase
  end

  assign bus.machineAcc     = accReg;
  assign bus.credit         = creditReg;
  assign bus.dispense_valid = dispValidReg;
  assign bus.dispense_item  = selReg;
  assign bus.change_valid   = changeValidReg;
  assign bus.change_amt     = changeAmtReg;
  assign bus.coin_reject    = coinRejReg;
  assign bus.err_funds      = errFundsReg;
  assign bus.err_full       = errFullReg;
  // Held low during reset so every output reads 0 while rst_n is asserted.
  assign bus.greenLight     = rst_n && !bus.mode && (stateReg == IDLE || stateReg == COLLECT);

endmodule
